fifo_arbiter: RTL and testbench

Round-robin scheduler that shares one 4-entry systolic-FFT sample FIFO between two producers and one consumer. Per cycle it selects at most one access, write or delete, because the FIFO cannot accept both in the same cycle. It shadows FIFO occupancy so it never issues a write when full or a delete when empty. It sits between the butterfly stages and the FIFO's `write`/`delete`/`fifo_in` pins, and its consumer port presents the FIFO head.

---
 rtl/fft_fifo_pkg.sv | 31 +++
 rtl/fifo_arbiter_if.sv | 60 ++++++
 rtl/rr_pick3.sv | 39 +++
 rtl/fifo_arbiter.sv | 109 ++++++++++
 tb/tb_fifo_arbiter.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/fft_fifo_pkg.sv
// ============================================================================
// fft_fifo_pkg : shared defaults, slot indices and slot type for fifo_arbiter
// Revision     : 1.0
// ============================================================================
`default_nettype none

package fft_fifo_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 4;

  typedef logic [1:0] slot_t;

  localparam slot_t SLOT_P0 = 2'd0;
  localparam slot_t SLOT_P1 = 2'd1;
  localparam slot_t SLOT_RD = 2'd2;

  // One-hot grant vector to the slot index it names (P0 when nothing set).
  function automatic slot_t gnt_to_slot(input logic [2:0] gnt);
    slot_t s;
    s = SLOT_P0;
    if (gnt[2])
      s = SLOT_RD;
    else if (gnt[1])
      s = SLOT_P1;
    return s;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_arbiter_if.sv
// ============================================================================
// fifo_arbiter_if : producer/consumer/FIFO-pin bundle around fifo_arbiter
//                   (gnt_cnt present only with FIFO_ARB_STATS_EN)
// Revision        : 1.0
// ============================================================================
`default_nettype none

interface fifo_arbiter_if
  import fft_fifo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [1:0]       wr_req;
  logic [WIDTH-1:0] wr_data0;
  logic [WIDTH-1:0] wr_data1;
  logic             rd_req;
  logic [1:0]       wr_gnt;
  logic             rd_gnt;
  logic [WIDTH-1:0] rd_data;
  logic             fifo_write;
  logic             fifo_delete;
  logic [WIDTH-1:0] fifo_in;
  logic [WIDTH-1:0] fifo_out;
  logic             fifo_error;
  logic [CW-1:0]    count;
  logic             full;
  logic             empty;
  logic             err_sticky;
  logic             err_clr;
`ifdef FIFO_ARB_STATS_EN
  logic [2:0][15:0] gnt_cnt;
`endif

  // Arbiter side
  modport master (
    input  wr_req, wr_data0, wr_data1, rd_req, fifo_out, fifo_error, err_clr,
    output wr_gnt, rd_gnt, rd_data, fifo_write, fifo_delete, fifo_in,
    output count, full, empty, err_sticky
`ifdef FIFO_ARB_STATS_EN
    , output gnt_cnt
`endif
  );

  // Producers, consumer and FIFO side
  modport slave (
    output wr_req, wr_data0, wr_data1, rd_req, fifo_out, fifo_error, err_clr,
    input  wr_gnt, rd_gnt, rd_data, fifo_write, fifo_delete, fifo_in,
    input  count, full, empty, err_sticky
`ifdef FIFO_ARB_STATS_EN
    , input gnt_cnt
`endif
  );

endinterface

`default_nettype wire

// File: rtl/rr_pick3.sv
// ============================================================================
// rr_pick3 : combinational 3-way round-robin picker, search starts at last+1
// Revision : 1.0
// ============================================================================
`default_nettype none

module rr_pick3
  import fft_fifo_pkg::*;
(
  input  logic [2:0] eligible,
  input  slot_t      last,
  output logic [2:0] gnt
);

  always_comb begin
    gnt = 3'b000;
    case (last)
      SLOT_P0: begin
        if      (eligible[1]) gnt = 3'b010;
        else if (eligible[2]) gnt = 3'b100;
        else if (eligible[0]) gnt = 3'b001;
      end
      SLOT_P1: begin
        if      (eligible[2]) gnt = 3'b100;
        else if (eligible[0]) gnt = 3'b001;
        else if (eligible[1]) gnt = 3'b010;
      end
      // SLOT_RD, and the unused encoding, restart at producer 0
      default: begin
        if      (eligible[0]) gnt = 3'b001;
        else if (eligible[1]) gnt = 3'b010;
        else if (eligible[2]) gnt = 3'b100;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/fifo_arbiter.sv
// ============================================================================
// fifo_arbiter : round-robin write/delete scheduler for a shared FFT FIFO,
//                with shadow occupancy and sticky error flag.
//                FIFO_ARB_STATS_EN adds per-slot saturating grant counters.
// Revision     : 1.0
// ============================================================================
`default_nettype none

module fifo_arbiter
  import fft_fifo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic           clk,
  input  logic           reset,
  fifo_arbiter_if.master bus
);

  localparam int          CW     = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] C_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] C_ZERO = '0;
  localparam logic [CW-1:0] C_ONE  = CW'(1);

  logic [CW-1:0] r_count;
  slot_t         r_last;
  logic          r_err;
  logic [2:0]    w_elig;
  logic [2:0]    w_gnt;
  logic          w_full;
  logic          w_empty;
  logic          w_write;
  logic          w_delete;
  logic          w_range_err;

  assign w_full  = (r_count == C_FULL);
  assign w_empty = (r_count == C_ZERO);

  // Gated by reset so grants drop the moment reset asserts.
  assign w_elig = {bus.rd_req & ~w_empty,
                   bus.wr_req[1] & ~w_full,
                   bus.wr_req[0] & ~w_full} & {3{reset}};

  rr_pick3 u_pick (
    .eligible (w_elig),
    .last     (r_last),
    .gnt      (w_gnt)
  );

  assign w_write  = w_gnt[0] | w_gnt[1];
  assign w_delete = w_gnt[2];

  assign w_range_err = (w_write & w_full) | (w_delete & w_empty) | (w_write & w_delete);

  assign bus.wr_gnt      = w_gnt[1:0];
  assign bus.rd_gnt      = w_gnt[2];
  assign bus.fifo_write  = w_write;
  assign bus.fifo_delete = w_delete;
  assign bus.fifo_in     = w_gnt[1] ? bus.wr_data1 : bus.wr_data0;
  assign bus.rd_data     = bus.fifo_out;
  assign bus.count       = r_count;
  assign bus.full        = w_full;
  assign bus.empty       = w_empty;
  assign bus.err_sticky  = r_err;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= C_ZERO;
      r_last  <= SLOT_RD;
    end else begin
      if (!w_range_err) begin
        if (w_write)
          r_count <= r_count + C_ONE;
        else if (w_delete)
          r_count <= r_count - C_ONE;
      end
      if (|w_gnt)
        r_last <= gnt_to_slot(w_gnt);
    end
  end

  // Set has priority over clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_err <= 1'b0;
    else if (bus.fifo_error || w_range_err)
      r_err <= 1'b1;
    else if (bus.err_clr)
      r_err <= 1'b0;
  end

`ifdef FIFO_ARB_STATS_EN
  generate
    for (genvar s = 0; s < 3; s++) begin : g_stats
      logic [15:0] r_cnt;
      always_ff @(posedge clk or negedge reset) begin
        if (!reset)
          r_cnt <= 16'h0000;
        else if (w_gnt[s] && (r_cnt != 16'hFFFF))
          r_cnt <= r_cnt + 16'h0001;
      end
      assign bus.gnt_cnt[s] = r_cnt;
    end
  endgenerate
`endif

endmodule

`default_nettype wire

// File: tb/tb_fifo_arbiter.sv
// ============================================================================
// tb_fifo_arbiter : directed self-checking bench for fifo_arbiter with a
//                   simple 4-entry FIFO model on the FIFO pins
// Revision        : 1.0
// ============================================================================
`default_nettype none

module tb_fifo_arbiter;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_bad;

  fifo_arbiter_if bus ();

  fifo_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Minimal FIFO on the write/delete pins, sharing the arbiter reset
  logic [7:0] fm_mem [4];
  logic [1:0] fm_wp;
  logic [1:0] fm_rp;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      fm_wp <= 2'd0;
      fm_rp <= 2'd0;
    end else begin
      if (bus.fifo_write) begin
        fm_mem[fm_wp] <= bus.fifo_in;
        fm_wp         <= fm_wp + 2'd1;
      end
      if (bus.fifo_delete)
        fm_rp <= fm_rp + 2'd1;
    end
  end

  assign bus.fifo_out = fm_mem[fm_rp];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset          = 1'b0;
    bus.wr_req     = 2'b00;
    bus.rd_req     = 1'b0;
    bus.wr_data0   = 8'h00;
    bus.wr_data1   = 8'h00;
    bus.fifo_error = 1'b0;
    bus.err_clr    = 1'b0;
    tick();
    tick();
    n_cmp++; if (bus.count !== 3'd0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", bus.count); end
    n_cmp++; if (bus.empty !== 1'b1) begin n_bad++; $display("FAIL reset_empty: got %b want 1", bus.empty); end
    n_cmp++; if (bus.full !== 1'b0) begin n_bad++; $display("FAIL reset_full: got %b want 0", bus.full); end
    n_cmp++; if (bus.err_sticky !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", bus.err_sticky); end
    n_cmp++; if ({bus.wr_gnt, bus.rd_gnt} !== 3'b000) begin n_bad++; $display("FAIL reset_gnt: got %b want 000", {bus.wr_gnt, bus.rd_gnt}); end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_single_write();
    bus.wr_req   = 2'b01;
    bus.wr_data0 = 8'hA5;
    #1;
    n_cmp++; if (bus.wr_gnt !== 2'b01) begin n_bad++; $display("FAIL single_gnt: got %b want 01", bus.wr_gnt); end
    n_cmp++; if (bus.fifo_in !== 8'hA5) begin n_bad++; $display("FAIL single_fifo_in: got %h want a5", bus.fifo_in); end
    n_cmp++; if (bus.fifo_write !== 1'b1) begin n_bad++; $display("FAIL single_write_pin: got %b want 1", bus.fifo_write); end
    tick();
    bus.wr_req = 2'b00;
    #1;
    n_cmp++; if (bus.count !== 3'd1) begin n_bad++; $display("FAIL single_count: got %0d want 1", bus.count); end
    n_cmp++; if (bus.rd_data !== 8'hA5) begin n_bad++; $display("FAIL single_rd_data: got %h want a5", bus.rd_data); end
    bus.rd_req = 1'b1;
    #1;
    n_cmp++; if (bus.rd_gnt !== 1'b1) begin n_bad++; $display("FAIL single_pop_gnt: got %b want 1", bus.rd_gnt); end
    tick();
    bus.rd_req = 1'b0;
    #1;
    n_cmp++; if (bus.empty !== 1'b1) begin n_bad++; $display("FAIL single_pop_empty: got %b want 1", bus.empty); end
  endtask

  task automatic test_fill();
    logic [1:0] exp_gnt [4];
    exp_gnt[0] = 2'b01; exp_gnt[1] = 2'b10; exp_gnt[2] = 2'b01; exp_gnt[3] = 2'b10;
    bus.wr_req   = 2'b11;
    bus.wr_data0 = 8'h10;
    bus.wr_data1 = 8'h21;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_cmp++; if (bus.wr_gnt !== exp_gnt[i]) begin n_bad++; $display("FAIL fill_gnt[%0d]: got %b want %b", i, bus.wr_gnt, exp_gnt[i]); end
      tick();
    end
    #1;
    n_cmp++; if (bus.count !== 3'd4) begin n_bad++; $display("FAIL fill_count: got %0d want 4", bus.count); end
    n_cmp++; if (bus.full !== 1'b1) begin n_bad++; $display("FAIL fill_full: got %b want 1", bus.full); end
    n_cmp++; if ({bus.wr_gnt, bus.fifo_write} !== 3'b000) begin n_bad++; $display("FAIL fill_fifth: got %b want 000", {bus.wr_gnt, bus.fifo_write}); end
    n_cmp++; if (bus.rd_data !== 8'h10) begin n_bad++; $display("FAIL fill_head: got %h want 10", bus.rd_data); end
    tick();
    n_cmp++; if (bus.count !== 3'd4) begin n_bad++; $display("FAIL fill_hold: got %0d want 4", bus.count); end
  endtask

  task automatic test_full_contention();
    logic [7:0] exp_data [4];
    exp_data[0] = 8'h21; exp_data[1] = 8'h10; exp_data[2] = 8'h21; exp_data[3] = 8'h10;
    bus.rd_req = 1'b1;
    bus.wr_req = 2'b11;
    #1;
    n_cmp++; if ({bus.wr_gnt, bus.rd_gnt} !== 3'b001) begin n_bad++; $display("FAIL cont_rd_only: got %b want 001", {bus.wr_gnt, bus.rd_gnt}); end
    tick();
    n_cmp++; if (bus.count !== 3'd3) begin n_bad++; $display("FAIL cont_count: got %0d want 3", bus.count); end
    n_cmp++; if ({bus.wr_gnt, bus.rd_gnt} !== 3'b010) begin n_bad++; $display("FAIL cont_next_p0: got %b want 010", {bus.wr_gnt, bus.rd_gnt}); end
    n_cmp++; if (bus.fifo_in !== 8'h10) begin n_bad++; $display("FAIL cont_fifo_in: got %h want 10", bus.fifo_in); end
    tick();
    bus.wr_req = 2'b00;
    n_cmp++; if (bus.count !== 3'd4) begin n_bad++; $display("FAIL cont_refill: got %0d want 4", bus.count); end
    for (int i = 0; i < 4; i++) begin
      #1;
      n_cmp++; if (bus.rd_gnt !== 1'b1) begin n_bad++; $display("FAIL drain_gnt[%0d]: got %b want 1", i, bus.rd_gnt); end
      n_cmp++; if (bus.rd_data !== exp_data[i]) begin n_bad++; $display("FAIL drain_data[%0d]: got %h want %h", i, bus.rd_data, exp_data[i]); end
      tick();
    end
    bus.rd_req = 1'b0;
    n_cmp++; if (bus.count !== 3'd0) begin n_bad++; $display("FAIL drain_count: got %0d want 0", bus.count); end
  endtask

  task automatic test_empty_read();
    bus.rd_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++; if ({bus.rd_gnt, bus.fifo_delete} !== 2'b00) begin n_bad++; $display("FAIL empty_rd[%0d]: got %b want 00", i, {bus.rd_gnt, bus.fifo_delete}); end
      tick();
      n_cmp++; if (bus.err_sticky !== 1'b0) begin n_bad++; $display("FAIL empty_err[%0d]: got %b want 0", i, bus.err_sticky); end
    end
    bus.rd_req = 1'b0;
    n_cmp++; if (bus.count !== 3'd0) begin n_bad++; $display("FAIL empty_count: got %0d want 0", bus.count); end
  endtask

  task automatic test_error();
    bus.fifo_error = 1'b1;
    tick();
    bus.fifo_error = 1'b0;
    n_cmp++; if (bus.err_sticky !== 1'b1) begin n_bad++; $display("FAIL err_set: got %b want 1", bus.err_sticky); end
    tick();
    n_cmp++; if (bus.err_sticky !== 1'b1) begin n_bad++; $display("FAIL err_hold: got %b want 1", bus.err_sticky); end
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    n_cmp++; if (bus.err_sticky !== 1'b0) begin n_bad++; $display("FAIL err_clear: got %b want 0", bus.err_sticky); end
    bus.err_clr    = 1'b1;
    bus.fifo_error = 1'b1;
    tick();
    bus.err_clr    = 1'b0;
    bus.fifo_error = 1'b0;
    n_cmp++; if (bus.err_sticky !== 1'b1) begin n_bad++; $display("FAIL err_set_wins: got %b want 1", bus.err_sticky); end
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
  endtask

  task automatic test_reset_mid();
    bus.wr_req   = 2'b01;
    bus.wr_data0 = 8'h3C;
    tick();
    tick();
    tick();
    bus.wr_req = 2'b00;
    n_cmp++; if (bus.count !== 3'd3) begin n_bad++; $display("FAIL mid_count_pre: got %0d want 3", bus.count); end
    #2;
    bus.wr_req = 2'b11;
    bus.rd_req = 1'b1;
    reset      = 1'b0;
    #1;
    n_cmp++; if (bus.count !== 3'd0) begin n_bad++; $display("FAIL mid_count: got %0d want 0", bus.count); end
    n_cmp++; if (bus.empty !== 1'b1) begin n_bad++; $display("FAIL mid_empty: got %b want 1", bus.empty); end
    n_cmp++; if ({bus.wr_gnt, bus.rd_gnt} !== 3'b000) begin n_bad++; $display("FAIL mid_gnt: got %b want 000", {bus.wr_gnt, bus.rd_gnt}); end
`ifdef FIFO_ARB_STATS_EN
    n_cmp++; if (bus.gnt_cnt !== 48'h0) begin n_bad++; $display("FAIL mid_stats: got %h want 0", bus.gnt_cnt); end
`endif
    tick();
    bus.wr_req = 2'b00;
    bus.rd_req = 1'b0;
    reset      = 1'b1;
    tick();
    n_cmp++; if (bus.count !== 3'd0) begin n_bad++; $display("FAIL mid_after: got %0d want 0", bus.count); end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_single_write();
    test_fill();
    test_full_contention();
    test_empty_read();
    test_error();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
